pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_slot.sv | 28 ++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared occupancy state and width definitions for pipeline stage registers.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

  function automatic logic [OCC_W-1:0] occ_of(input occ_state_e s);
    return OCC_W'(s);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register: load enable, synchronous clear to RST_VAL, async active-low reset.
// Latency: one edge from load to q; no flow control of its own.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear wins over load so a flush always leaves the bubble value behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (clear) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional skid slot; out_data comes straight from a flop.
// Latency one cycle; SKID=1 gives a registered in_ready, SKID=0 passes out_ready through to in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                SKID    = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [OCC_W-1:0]  occ
);

  localparam bit HAS_SKID = (SKID != 0);

  occ_state_e        state;
  occ_state_e        state_nxt;
  logic              xfer_in;
  logic              xfer_out;
  logic              main_load;
  logic              skid_load;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // With a skid slot, ready depends only on the state flop, breaking the out_ready timing path.
  always_comb begin
    if (HAS_SKID) begin
      in_ready = (state != TWO);
    end else begin
      in_ready = (state == EMPTY) | out_ready;
    end
  end

  assign out_valid = (state != EMPTY);
  assign occ       = occ_of(state);
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_data;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (xfer_in) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            main_load = 1'b1;
          end else if (xfer_in) begin
            // Without a skid slot ready implies out_ready here, so this arm is SKID-only.
            if (HAS_SKID) begin
              state_nxt = TWO;
              skid_load = 1'b1;
            end
          end else if (xfer_out) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (xfer_out) begin
            state_nxt = ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .RST_VAL(RST_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .load (main_load),
    .d    (main_d),
    .q    (out_data)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .RST_VAL(RST_VAL)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 instance a, SKID=0 instance b, vectors plus queue-model random run.
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_iv, a_ir, a_ov, a_or, a_fl;
  logic [W-1:0] a_id, a_od;
  logic [1:0]   a_occ;
  logic         b_iv, b_ir, b_ov, b_or, b_fl;
  logic [W-1:0] b_id, b_od;
  logic [1:0]   b_occ;

  pipe_stage_reg #(.DATA_W(W), .SKID(1), .RST_VAL('0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .flush(a_fl), .occ(a_occ)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(0), .RST_VAL('0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .flush(b_fl), .occ(b_occ)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  function automatic vec_t mkv(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic fl, input logic ov, input logic [31:0] od,
                               input logic [1:0] occ, input logic ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  vec_t tbl[17];

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] bub_a;
  logic [31:0] bub_b;

  initial begin
    // expected values are the outputs sampled just after the edge that applied the row
    tbl[0]  = mkv(1, 32'h1,  1, 0,  1, 32'h1,  2'd1, 1);
    tbl[1]  = mkv(1, 32'h2,  1, 0,  1, 32'h2,  2'd1, 1);
    tbl[2]  = mkv(1, 32'h3,  1, 0,  1, 32'h3,  2'd1, 1);
    tbl[3]  = mkv(1, 32'h4,  1, 0,  1, 32'h4,  2'd1, 1);
    tbl[4]  = mkv(0, 32'h0,  1, 0,  0, 32'h4,  2'd0, 1);
    tbl[5]  = mkv(1, 32'hA,  0, 0,  1, 32'hA,  2'd1, 1);
    tbl[6]  = mkv(1, 32'hB,  0, 0,  1, 32'hA,  2'd2, 0);
    tbl[7]  = mkv(1, 32'hC,  0, 0,  1, 32'hA,  2'd2, 0);
    tbl[8]  = mkv(1, 32'hC,  1, 0,  1, 32'hB,  2'd1, 1);
    tbl[9]  = mkv(1, 32'hC,  1, 0,  1, 32'hC,  2'd1, 1);
    tbl[10] = mkv(0, 32'h0,  1, 0,  0, 32'hC,  2'd0, 1);
    tbl[11] = mkv(1, 32'h11, 0, 0,  1, 32'h11, 2'd1, 1);
    tbl[12] = mkv(1, 32'h22, 0, 0,  1, 32'h11, 2'd2, 0);
    tbl[13] = mkv(1, 32'h55, 0, 1,  0, 32'h0,  2'd0, 1);
    tbl[14] = mkv(0, 32'h0,  1, 0,  0, 32'h0,  2'd0, 1);
    tbl[15] = mkv(1, 32'h66, 1, 0,  1, 32'h66, 2'd1, 1);
    tbl[16] = mkv(1, 32'h77, 1, 1,  0, 32'h0,  2'd0, 1);

    // reset held with a payload offered on both instances
    rst  = 1'b0;
    a_iv = 1'b1; a_id = 32'hDEADBEEF; a_or = 1'b0; a_fl = 1'b0;
    b_iv = 1'b1; b_id = 32'hDEADBEEF; b_or = 1'b0; b_fl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst a out_valid", a_ov, 0);
    chk("rst a out_data", a_od, 0);
    chk("rst a occ", a_occ, 0);
    chk("rst a in_ready", a_ir, 1);
    chk("rst b out_valid", b_ov, 0);
    chk("rst b out_data", b_od, 0);
    chk("rst b occ", b_occ, 0);
    chk("rst b in_ready", b_ir, 1);
    @(negedge clk);
    rst  = 1'b1;
    a_iv = 1'b0;
    b_iv = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      a_iv = tbl[i].iv; a_id = tbl[i].d; a_or = tbl[i].ordy; a_fl = tbl[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), a_ov, tbl[i].ov);
      chk($sformatf("vec%0d out_data", i), a_od, tbl[i].od);
      chk($sformatf("vec%0d occ", i), a_occ, tbl[i].occ);
      chk($sformatf("vec%0d in_ready", i), a_ir, tbl[i].ir);
    end
    @(negedge clk);
    a_iv = 1'b0; a_or = 1'b0; a_fl = 1'b0;

    // SKID=0: in_ready follows out_ready combinationally, replace in place
    @(negedge clk);
    b_iv = 1'b1; b_id = 32'h10; b_or = 1'b0;
    #1 chk("skid0 ready empty", b_ir, 1);
    @(posedge clk);
    #1;
    chk("skid0 first data", b_od, 32'h10);
    chk("skid0 first occ", b_occ, 1);
    chk("skid0 stalled ready", b_ir, 0);
    @(negedge clk);
    b_or = 1'b1; b_id = 32'h20;
    #1 chk("skid0 ready follows out_ready", b_ir, 1);
    @(posedge clk);
    #1;
    chk("skid0 replace data", b_od, 32'h20);
    chk("skid0 replace occ", b_occ, 1);
    chk("skid0 replace valid", b_ov, 1);
    @(negedge clk);
    b_or = 1'b0; b_id = 32'h30;
    #1 chk("skid0 ready drops", b_ir, 0);
    @(posedge clk);
    #1;
    chk("skid0 ignored data", b_od, 32'h20);
    chk("skid0 held occ", b_occ, 1);
    @(negedge clk);
    b_iv = 1'b0; b_or = 1'b1;
    @(posedge clk);
    #1;
    chk("skid0 drain valid", b_ov, 0);
    chk("skid0 drain occ", b_occ, 0);

    // reset asserted between edges must clear state immediately
    @(negedge clk);
    a_iv = 1'b1; a_id = 32'h99; a_or = 1'b0;
    b_iv = 1'b0; b_or = 1'b0;
    @(posedge clk);
    #1 chk("pre-async occ", a_occ, 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst out_valid", a_ov, 0);
    chk("async rst occ", a_occ, 0);
    chk("async rst out_data", a_od, 0);
    chk("async rst in_ready", a_ir, 1);
    @(negedge clk);
    rst  = 1'b1;
    a_iv = 1'b0;

    // random traffic against queue models
    qa.delete(); qb.delete();
    bub_a = '0; bub_b = '0;
    for (int c = 0; c < 600; c++) begin
      logic        iv, ordy, fl;
      logic [31:0] d;
      logic        push_a, pop_a, push_b, pop_b;
      logic        rdy_a, rdy_b;
      @(negedge clk);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 15) == 0);
      d    = $urandom;
      a_iv = iv; a_or = ordy; a_fl = fl; a_id = d;
      b_iv = iv; b_or = ordy; b_fl = fl; b_id = d;
      #1;
      rdy_a = (qa.size() < 2);
      rdy_b = (qb.size() == 0) || ordy;
      chk("rand a out_valid", a_ov, qa.size() != 0);
      chk("rand a out_data", a_od, (qa.size() != 0) ? qa[0] : bub_a);
      chk("rand a occ", a_occ, qa.size());
      chk("rand a in_ready", a_ir, rdy_a);
      chk("rand b out_valid", b_ov, qb.size() != 0);
      chk("rand b out_data", b_od, (qb.size() != 0) ? qb[0] : bub_b);
      chk("rand b occ", b_occ, qb.size());
      chk("rand b in_ready", b_ir, rdy_b);
      push_a = iv & rdy_a;
      pop_a  = (qa.size() != 0) & ordy;
      push_b = iv & rdy_b;
      pop_b  = (qb.size() != 0) & ordy;
      @(posedge clk);
      if (fl) begin
        qa.delete(); qb.delete();
        bub_a = '0; bub_b = '0;
      end else begin
        if (pop_a) bub_a = qa.pop_front();
        if (push_a) qa.push_back(d);
        if (pop_b) bub_b = qb.pop_front();
        if (push_b) qb.push_back(d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
